// File: rtl/nanocalc_pkg.sv
// nanocalc_pkg: shared types for the nanocalc result path.
//   OP_W           - opcode width
//   RESULT_W       - default ALU result width
//   opcode_e       - ALU opcode encoding
//   result_entry_t - {op, carry, zero, result} entry at the default result width
//   entry_width()  - entry width for an arbitrary result width
package nanocalc_pkg;

    localparam int unsigned OP_W     = 3;
    localparam int unsigned RESULT_W = 4;

    typedef enum logic [OP_W-1:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4,
        OpNot = 3'd5,
        OpShl = 3'd6,
        OpEq  = 3'd7
    } opcode_e;

    typedef struct packed {
        opcode_e               op;
        logic                  carry;
        logic                  zero;
        logic [RESULT_W-1:0]   result;
    } result_entry_t;

    // Opcode plus carry and zero flags sit above the result bits.
    function automatic int unsigned entry_width(int unsigned w);
        return w + OP_W + 2;
    endfunction

endpackage

// File: rtl/nanocalc_sync_fifo.sv
// nanocalc_sync_fifo: generic in-order FIFO storage with pointers and occupancy count.
//   clk, rst       - clock, asynchronous active-high reset
//   clear          - synchronous flush of pointers and count (storage kept)
//   push, wdata    - write request and data; ignored while full
//   pop            - read advance; ignored while empty
//   rdata          - entry at the read pointer (register read)
//   count          - occupancy; full/empty are decoded from it
module nanocalc_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Full/empty come from count so pointer equality is never ambiguous.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/nanocalc_result_fifo.sv
// nanocalc_result_fifo: captures ALU results with flags and opcode into an in-order FIFO,
// tracks the last accepted result (acc) and a sticky overflow flag (drop).
//   clk, rst                 - clock, asynchronous active-high reset
//   clear                    - synchronous flush; wins over push and pop
//   in_valid/in_ready        - capture handshake; in_result/carry/zero/op are the entry
//   out_valid/out_ready      - head handshake; out_result/carry/zero/op show the head
//   acc                      - result of the last accepted push
//   count                    - occupancy
//   drop                     - sticky: push attempted while full
// Build option: define NANOCALC_ZERO_SKIP_EN to accept zero-flagged results without storing them.
module nanocalc_result_fifo
    import nanocalc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_result,
    input  logic                     in_carry,
    input  logic                     in_zero,
    input  logic [OP_W-1:0]          in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_result,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [OP_W-1:0]          out_op,
    output logic [W-1:0]             acc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int unsigned EntryW = entry_width(W);

    typedef struct packed {
        opcode_e         op;
        logic            carry;
        logic            zero;
        logic [W-1:0]    result;
    } entry_t;

    entry_t              wr_entry, rd_entry;
    logic [EntryW-1:0]   wr_data, rd_data;
    logic                full, empty;
    logic                accept, fifo_push, fifo_pop;
    logic [W-1:0]        acc_q, acc_d;
    logic                drop_q, drop_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign fifo_pop  = out_valid && out_ready;

`ifdef NANOCALC_ZERO_SKIP_EN
    // Zero results are acknowledged upstream but never occupy a slot.
    assign fifo_push = accept && !in_zero;
`else
    assign fifo_push = accept;
`endif

    always_comb begin
        wr_entry        = '0;
        wr_entry.op     = opcode_e'(in_op);
        wr_entry.carry  = in_carry;
        wr_entry.zero   = in_zero;
        wr_entry.result = in_result;
    end

    assign wr_data  = wr_entry;
    assign rd_entry = rd_data;

    nanocalc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW),
        .CNT_W ($clog2(DEPTH) + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_data),
        .rdata (rd_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        acc_d  = acc_q;
        drop_d = drop_q;
        if (clear) begin
            acc_d  = '0;
            drop_d = 1'b0;
        end else begin
            if (accept)                acc_d  = in_result;
            if (in_valid && !in_ready) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            drop_q <= drop_d;
        end
    end

    assign acc        = acc_q;
    assign drop       = drop_q;
    assign out_result = rd_entry.result;
    assign out_carry  = rd_entry.carry;
    assign out_zero   = rd_entry.zero;
    assign out_op     = rd_entry.op;

endmodule

// File: tb/tb_nanocalc_result_fifo.sv
// tb_nanocalc_result_fifo: randomized scoreboard bench for nanocalc_result_fifo.
// The reference model is a plain queue of entries plus acc/drop scalars.
module tb_nanocalc_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef NANOCALC_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clear;
    logic          in_valid, in_ready, in_carry, in_zero;
    logic [W-1:0]  in_result, out_result, acc;
    logic [2:0]    in_op, out_op;
    logic          out_valid, out_ready, out_carry, out_zero, drop;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [2:0]   op;
        logic         carry;
        logic         zero;
        logic [W-1:0] result;
    } ent_t;

    ent_t exp_q[$];   // scoreboard: entries expected at the output, in order
    ent_t mdl_q[$];   // occupancy model
    int   acc_m;
    bit   drop_m;
    int   passes = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    nanocalc_result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_zero    (in_zero),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_op     (out_op),
        .acc        (acc),
        .count      (count),
        .drop       (drop)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every output handshake must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            check("out_has_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_result", int'(out_result), int'(e.result));
                check("out_carry",  int'(out_carry),  int'(e.carry));
                check("out_zero",   int'(out_zero),   int'(e.zero));
                check("out_op",     int'(out_op),     int'(e.op));
            end
        end
    end

    task automatic check_status();
        check("out_valid", int'(out_valid), int'(mdl_q.size() != 0));
        check("in_ready",  int'(in_ready),  int'(mdl_q.size() < int'(DEPTH)));
        check("count",     int'(count),     mdl_q.size());
        check("acc",       int'(acc),       acc_m);
        check("drop",      int'(drop),      int'(drop_m));
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        acc_m  = 0;
        drop_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, check state mid-cycle, then advance the model at the edge.
    task automatic step(input bit iv, input logic [W-1:0] res, input bit c, input bit z,
                        input logic [2:0] op, input bit orr, input bit clr);
        ent_t e;
        bit   was_full, do_pop;
        in_valid  = iv;
        in_result = res;
        in_carry  = c;
        in_zero   = z;
        in_op     = op;
        out_ready = orr;
        clear     = clr;
        @(negedge clk);
        check_status();
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            was_full = (mdl_q.size() == int'(DEPTH));
            do_pop   = (mdl_q.size() != 0) && orr;
            if (iv && was_full) drop_m = 1'b1;
            if (do_pop) void'(mdl_q.pop_front());
            if (iv && !was_full) begin
                acc_m = int'(res);
                if (!(ZeroSkip && z)) begin
                    e = '{op: op, carry: c, zero: z, result: res};
                    mdl_q.push_back(e);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input bit orr);
        step(1'b0, '0, 1'b0, 1'b0, 3'd0, orr, 1'b0);
    endtask

    task automatic push(input logic [W-1:0] res, input bit orr);
        step(1'b1, res, 1'b0, (res == '0), 3'($urandom_range(0, 7)), orr, 1'b0);
    endtask

    initial begin
        int pp, pr;
        bit iv, orr, clr;
        logic [W-1:0] r;
        rst = 1'b1;
        clear = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
        in_zero = 1'b0; in_op = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state while idle.
        idle(1'b0);

        // Single ADD push of 0xA, visible the next cycle, then drained.
        step(1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(1'b0);
        check("first_head", int'(out_result), 'hA);
        idle(1'b1);

        // Fill to DEPTH then overflow with 0x5; drain all four.
        for (int i = 1; i <= 5; i++) push(W'(i), 1'b0);
        idle(1'b0);
        check("full_count", int'(count), int'(DEPTH));
        check("full_drop", int'(drop), 1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Steady stream at count=2 across pointer wrap.
        push(4'h7, 1'b0);
        push(4'h8, 1'b0);
        for (int i = 0; i < 10; i++) push(W'($urandom_range(1, 15)), 1'b1);
        idle(1'b0);
        check("stream_count", int'(count), 2);

        // count=3 with drop set, then clear alongside push and pop.
        for (int i = 0; i < 3; i++) push(W'($urandom_range(1, 15)), 1'b0);
        push(4'h3, 1'b0);
        idle(1'b1);
        step(1'b1, 4'h9, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        idle(1'b0);
        check("clear_count", int'(count), 0);

        // Zero-result push.
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        idle(1'b0);
        check("zero_count", int'(count), ZeroSkip ? 0 : 1);
        idle(1'b1);

        // Randomized phases with varying push/pop pressure.
        for (int ph = 0; ph < 8; ph++) begin
            pp = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 80; i++) begin
                iv  = ($urandom_range(0, 99) < pp);
                orr = ($urandom_range(0, 99) < pr);
                clr = ($urandom_range(0, 59) == 0);
                r   = W'($urandom);
                step(iv, r, 1'($urandom), (r == '0), 3'($urandom), orr, clr);
            end
            if (ph == 4) begin
                // Asynchronous reset in the middle of traffic.
                in_valid = 1'b1;
                out_ready = 1'b1;
                rst = 1'b1;
                model_reset();
                #2;
                check_status();
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/nanocalc_result_fifo.md
Name: nanocalc_result_fifo

Overview:
- Downstream stage of the nanocalc ALU. Captures each ALU result together with its carry flag, zero flag and opcode into a small in-order FIFO.
- Presents captured entries to the output/display logic over a valid/ready handshake.
- Keeps a running accumulator of the last accepted result, which the operand-select logic feeds back as operand A for chained calculations.
- Decouples the combinational ALU from slower consumers (display scan, serial dump).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- W, 4, ALU result width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous assert, active-high
- clear  input  1  synchronous flush of FIFO, accumulator and sticky flag
- in_valid  input  1  ALU result valid (capture strobe)
- in_ready  output  1  FIFO can accept an entry
- in_result  input  W  ALU result
- in_carry  input  1  ALU carry/overflow flag
- in_zero  input  1  ALU zero flag
- in_op  input  3  ALU opcode that produced the result
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head entry
- out_result  output  W  head entry result
- out_carry  output  1  head entry carry
- out_zero  output  1  head entry zero
- out_op  output  3  head entry opcode
- acc  output  W  last accepted result
- count  output  $clog2(DEPTH)+1  current occupancy
- drop  output  1  sticky: a push was attempted while full

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: all entries, pointers, count, acc and drop = 0. Hence out_valid=0 and in_ready=1. Reset mid-transfer discards everything, with no partial entry.
- Entry: {op[2:0], carry, zero, result[W-1:0]}, i.e. W+5 bits.
- Push: in_valid && in_ready. The entry is written at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH and count decrements.
- in_ready = (count != DEPTH). No push-through when full, even if out_ready=1 in the same cycle.
- out_valid = (count != 0). The out_* fields show the entry at rd_ptr and are stable while out_valid && !out_ready.
- Latency: an entry pushed in cycle N is visible at out_* in cycle N+1. There is no same-cycle fall-through when empty.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Occupancy states, derived from count:
  - EMPTY (count=0) -> PARTIAL on push.
  - PARTIAL -> FULL on push-only reaching DEPTH.
  - PARTIAL -> EMPTY on pop-only reaching 0.
  - FULL -> PARTIAL on pop.
- Pointers wrap modulo DEPTH; the full/empty decision uses count, not pointer equality.
- acc: loaded with in_result on every accepted push, one cycle after the push edge. It holds otherwise, and is unaffected by pops.
- drop: set when in_valid && !in_ready; held until clear or rst.
- clear: takes priority over push and pop in the same cycle. Pointers, count, acc and drop go to 0. Entry storage need not be zeroed.
- All outputs are driven from registers or decoded directly from registered count. There is no combinational path from in_* to out_*.

Optional Feature:
- Macro: NANOCALC_ZERO_SKIP_EN.
- Defined: pushes with in_zero=1 are accepted (in_ready unchanged) but not stored. count and wr_ptr are unchanged and acc still loads 0.
- Undefined: zero results are stored like any other entry.

Decomposition:
- Package nanocalc_pkg:
  - opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, EQ=7.
  - result_entry_t packed struct: op, carry, zero, result.
  - OP_W=3 constant.
- Sub-module nanocalc_sync_fifo: generic storage, pointers and count. The top adds acc, drop, clear priority and the zero-skip filter.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, acc=0, drop=0.
- Push {op=ADD, result=0xA, carry=0, zero=0} with out_ready=0 -> next cycle out_valid=1, out_result=0xA, out_op=0, acc=0xA, count=1.
- Push 4 entries (0x1, 0x2, 0x3, 0x4) with out_ready=0, then a 5th (0x5) -> in_ready=0 after the 4th, drop=1, count=4. Popping yields 0x1, 0x2, 0x3, 0x4 in order; 0x5 is never output.
- Steady stream at count=2 with in_valid=out_ready=1 for 10 cycles -> count stays 2, order preserved across pointer wrap.
- FIFO at count=3 with drop=1; assert clear together with in_valid and out_ready -> next cycle count=0, acc=0, drop=0, out_valid=0.
- Push result=0x0, zero=1 -> count increments with the macro undefined; count stays unchanged with NANOCALC_ZERO_SKIP_EN defined. In both builds acc=0x0.
